// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring divide,
// one bit per cycle, with a Start/Busy/Done handshake beside the single-cycle ALU.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Start,
  input  logic [2:0]       MDCtl,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] MDResult
);

  // state  | meaning
  // S_IDLE | waiting for Start
  // S_MUL  | shift-add iteration, one multiplier bit per cycle
  // S_DIV  | restoring division, one quotient bit per cycle
  // S_FIX  | sign correction and result select
  // S_DONE | Done pulse; Start may be accepted here
  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [2:0]       op_q;
  logic             a_neg_q, b_neg_q;
  logic [WIDTH-1:0] opnd_q;
  logic [WIDTH-1:0] acc_hi_q, acc_lo_q;

  logic             accept, signed_a, signed_b, a_neg, b_neg;
  logic             div_zero, div_ovf, special;
  logic [WIDTH-1:0] abs_a, abs_b, special_res;
  logic [WIDTH:0]   mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] prod_mag, prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix, fix_res;

  assign accept = Start && (state_q == S_IDLE || state_q == S_DONE);

  always_comb begin
    signed_a = 1'b0;
    signed_b = 1'b0;
    case (MDCtl)
      3'd0, 3'd1, 3'd4, 3'd6: begin signed_a = 1'b1; signed_b = 1'b1; end
      3'd2:                   signed_a = 1'b1;
      default:                ;
    endcase
  end

  assign a_neg = signed_a & SrcA[WIDTH-1];
  assign b_neg = signed_b & SrcB[WIDTH-1];
  assign abs_a = a_neg ? -SrcA : SrcA;
  assign abs_b = b_neg ? -SrcB : SrcB;

  assign div_zero = MDCtl[2] && (SrcB == '0);
  assign div_ovf  = MDCtl[2] && !MDCtl[0] && (SrcA == {1'b1, {(WIDTH-1){1'b0}}}) && (SrcB == '1);
  assign special  = div_zero || div_ovf;
  // MDCtl[1] separates remainder ops from quotient ops
  assign special_res = div_zero ? (MDCtl[1] ? SrcA : '1) : (MDCtl[1] ? '0 : SrcA);

  // MUL: acc_hi accumulates, acc_lo shifts the multiplier out and the product low half in.
  // DIV: acc_hi is the partial remainder, acc_lo shifts the dividend out and quotient in.
  assign mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
  assign div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opnd_q};

  assign prod_mag = {acc_hi_q, acc_lo_q};
  assign prod_fix = (a_neg_q ^ b_neg_q) ? -prod_mag : prod_mag;
  assign quo_fix  = (a_neg_q ^ b_neg_q) ? -acc_lo_q : acc_lo_q;
  assign rem_fix  = a_neg_q ? -acc_hi_q : acc_hi_q;

  always_comb begin
    fix_res = '0;
    case (op_q)
      3'd0:             fix_res = prod_fix[WIDTH-1:0];
      3'd1, 3'd2, 3'd3: fix_res = prod_fix[2*WIDTH-1:WIDTH];
      3'd4, 3'd5:       fix_res = quo_fix;
      default:          fix_res = rem_fix;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          if (special)       state_d = S_DONE;
          else if (MDCtl[2]) state_d = S_DIV;
          else               state_d = S_MUL;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MUL, S_DIV: if (cnt_q == CW'(1)) state_d = S_FIX;
      S_FIX:        state_d = S_DONE;
      default:      state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      a_neg_q  <= 1'b0;
      b_neg_q  <= 1'b0;
      opnd_q   <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      MDResult <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q     <= MDCtl;
        a_neg_q  <= a_neg;
        b_neg_q  <= b_neg;
        opnd_q   <= MDCtl[2] ? abs_b : abs_a;
        acc_hi_q <= '0;
        acc_lo_q <= MDCtl[2] ? abs_a : abs_b;
        cnt_q    <= CW'(WIDTH);
        if (special) MDResult <= special_res;
      end else begin
        case (state_q)
          S_MUL: begin
            acc_hi_q <= mul_sum[WIDTH:1];
            acc_lo_q <= {mul_sum[0], acc_lo_q[WIDTH-1:1]};
            cnt_q    <= cnt_q - CW'(1);
          end
          S_DIV: begin
            acc_hi_q <= div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
            acc_lo_q <= {acc_lo_q[WIDTH-2:0], ~div_diff[WIDTH]};
            cnt_q    <= cnt_q - CW'(1);
          end
          S_FIX:   MDResult <= fix_res;
          default: ;
        endcase
      end
    end
  end

  assign Busy = (state_q == S_MUL) || (state_q == S_DIV) || (state_q == S_FIX);
  assign Done = (state_q == S_DONE);

endmodule
